switch_fabric_arbiter: RTL and testbench
========================================

SWITCH_FABRIC_ARBITER -- requirements
Module: switch_fabric_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 24, number of ingress streams (range 2-32).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, data bits per beat.
REQ-003 SHALL have parameter MAX_BEATS, default 190, the maximum number of beats forwarded per frame (range 2-65535).
REQ-004 SHALL have port clk_fabric  in  1  sole clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-006 SHALL have port in_tvalid  in  NUM_PORTS  per-port beat valid.
REQ-007 SHALL have port in_tready  out  NUM_PORTS  per-port beat ready.
REQ-008 SHALL have port in_tdata  in  NUM_PORTS*DATA_WIDTH  per-port data; port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port in_tlast  in  NUM_PORTS  per-port end of frame.
REQ-010 SHALL have port in_tuser  in  NUM_PORTS  per-port frame error flag.
REQ-011 SHALL have port port_enable  in  NUM_PORTS  1 = forward this port's frames; 0 = discard them.
REQ-012 SHALL have port out_tvalid/out_tready/out_tdata/out_tlast/out_tuser  out/in/out/out/out  1/1/DATA_WIDTH/1/1  egress stream.
REQ-013 SHALL have port out_tdest  out  $clog2(NUM_PORTS)  ingress port index of the current frame.
REQ-014 SHALL have port frames_forwarded, frames_discarded, frames_truncated  out  32 each  event counters.

Function
REQ-015 SHALL implement an FSM with states IDLE, FORWARD and DISCARD.
REQ-016 In IDLE, SHALL select the lowest-distance requester (in_tvalid=1), searching from last_grant+1 upward with wrap-around modulo NUM_PORTS.
REQ-017 In IDLE with a requester present, SHALL latch grant, set last_grant=grant, and go to FORWARD if port_enable[grant]=1, else to DISCARD.
REQ-018 In IDLE with no requester, SHALL remain in IDLE.
REQ-019 SHALL drive in_tready=0 and out_tvalid=0 on all ports in IDLE, giving one arbitration bubble cycle per frame.
REQ-020 SHALL sample port_enable only at the grant; changes during a frame SHALL have no effect until the next grant.
REQ-021 In FORWARD, data path SHALL be combinational with zero latency: out_tvalid=in_tvalid[grant], in_tready[grant]=out_tready, out_tdata/out_tuser from grant, out_tdest=grant; all other in_tready=0.
REQ-022 SHALL keep a beat counter, reset to 0 at grant and incremented on each FORWARD handshake.
REQ-023 On the handshake of beat number MAX_BEATS (counter==MAX_BEATS-1), SHALL force out_tlast=1 and out_tuser=1.
REQ-024 On that truncating handshake, SHALL increment frames_truncated; if in_tlast[grant]=0, SHALL go to DISCARD, else go to IDLE.
REQ-025 On a FORWARD handshake with in_tlast=1 that is not truncated, SHALL pass out_tlast=1, increment frames_forwarded, and go to IDLE.
REQ-026 A truncated frame SHALL NOT also increment frames_forwarded.
REQ-027 In DISCARD, SHALL drive in_tready[grant]=1 and out_tvalid=0, consuming beats until a beat with in_tlast=1, then go to IDLE.
REQ-028 SHALL increment frames_discarded on exit from DISCARD only when entered from IDLE, i.e. for a disabled port, not for a truncation tail.
REQ-029 out_tvalid SHALL never deassert while in FORWARD unless in_tvalid[grant] deasserts (no insertion of gaps by the block).
REQ-030 Counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-031 Simultaneous requests from all ports SHALL be served in strict rotation, with no port served twice before every other requester is served once.

Reset
REQ-032 While rst_n=0 at a clock edge: state=IDLE, last_grant=NUM_PORTS-1 (port 0 wins first), beat counter=0, all counters=0.
REQ-033 During reset, all in_tready=0, out_tvalid=0, out_tlast=0, out_tuser=0, out_tdest=0 and out_tdata=0.
REQ-034 Reset mid-frame SHALL abandon the frame without emitting out_tlast; the upstream remainder is treated as a new frame afterwards.

Verification
REQ-035 Ports 0,1,2 each present one 4-beat frame simultaneously, out_tready=1 -> egress order tdest 0,1,2; one idle cycle between frames; frames_forwarded=3.
REQ-036 port_enable[3]=0 and port 3 sends 5 beats -> in_tready[3]=1 for 5 cycles, out_tvalid stays 0, frames_discarded=1.
REQ-037 With MAX_BEATS=4, a 7-beat frame -> 4 beats out with out_tlast=1 and out_tuser=1 on beat 4, 3 beats absorbed, frames_truncated=1, frames_forwarded=0, frames_discarded=0.
REQ-038 out_tready toggles 1,0,1,0 during a frame -> no beat lost or duplicated; in_tready[grant] mirrors out_tready every cycle.
REQ-039 Port 1 granted and port_enable[1] cleared at beat 2 -> frame completes normally; the next port-1 frame is discarded.
REQ-040 rst_n=0 for one cycle at beat 3 of 6 -> outputs take their reset values; after release, port 0 wins arbitration and the residual 3 beats form a new frame.

Source files
------------

// File: rtl/switch_fabric_arbiter.sv
// Switch fabric arbiter: merges NUM_PORTS ingress AXI-Stream-like sources
// onto one egress stream, one whole frame at a time, using round-robin
// arbitration. Frames from disabled ports are drained silently. Frames
// longer than MAX_BEATS are cut short with tlast/tuser forced on the last
// forwarded beat, and their tail is absorbed.
module switch_fabric_arbiter #(
  parameter int NUM_PORTS  = 24,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BEATS  = 190
) (
  input  logic                             clk_fabric,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             in_tvalid,
  output logic [NUM_PORTS-1:0]             in_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  in_tdata,
  input  logic [NUM_PORTS-1:0]             in_tlast,
  input  logic [NUM_PORTS-1:0]             in_tuser,
  input  logic [NUM_PORTS-1:0]             port_enable,
  output logic                             out_tvalid,
  input  logic                             out_tready,
  output logic [DATA_WIDTH-1:0]            out_tdata,
  output logic                             out_tlast,
  output logic                             out_tuser,
  output logic [$clog2(NUM_PORTS)-1:0]     out_tdest,
  output logic [31:0]                      frames_forwarded,
  output logic [31:0]                      frames_discarded,
  output logic [31:0]                      frames_truncated
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int BW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FORWARD = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   grant;
  logic [PW-1:0]   last_grant;
  logic [BW-1:0]   beat_cnt;
  logic            disc_from_idle;

  logic            hi_found;
  logic            lo_found;
  logic [PW-1:0]   hi_idx;
  logic [PW-1:0]   lo_idx;
  logic            req_any;
  logic [PW-1:0]   arb_grant;

  logic                  sel_valid;
  logic                  sel_last;
  logic                  sel_user;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  at_limit;
  logic                  fwd_hs;
  logic                  disc_hs;

  // Round-robin search: the lowest requester above last_grant wins, otherwise
  // the lowest requester at or below it (wrap-around); last_grant itself is last.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (in_tvalid[p]) begin
        if (p > int'(last_grant)) begin
          hi_found = 1'b1;
          hi_idx   = PW'(p);
        end else begin
          lo_found = 1'b1;
          lo_idx   = PW'(p);
        end
      end
    end
    req_any   = hi_found | lo_found;
    arb_grant = hi_found ? hi_idx : lo_idx;
  end

  // Select the granted port's stream and decode handshakes for this cycle.
  always_comb begin
    sel_valid = in_tvalid[grant];
    sel_last  = in_tlast[grant];
    sel_user  = in_tuser[grant];
    sel_data  = in_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    at_limit  = (beat_cnt == BW'(MAX_BEATS - 1));
    fwd_hs    = (state == FORWARD) && sel_valid && out_tready;
    disc_hs   = (state == DISCARD) && sel_valid;
  end

  // Zero-latency egress mux; everything is held at zero while rst_n is low so
  // the outputs are quiet even before the first reset edge has been seen.
  always_comb begin
    in_tready  = '0;
    out_tvalid = 1'b0;
    out_tdata  = '0;
    out_tlast  = 1'b0;
    out_tuser  = 1'b0;
    out_tdest  = '0;
    if (rst_n) begin
      case (state)
        FORWARD: begin
          out_tvalid       = sel_valid;
          out_tdata        = sel_data;
          out_tlast        = sel_last | at_limit;
          out_tuser        = sel_user | at_limit;
          out_tdest        = grant;
          in_tready[grant] = out_tready;
        end
        DISCARD: begin
          in_tready[grant] = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Frame-level FSM: grant in IDLE, forward or drain the frame, count outcomes.
  always_ff @(posedge clk_fabric) begin
    if (!rst_n) begin
      state            <= IDLE;
      grant            <= '0;
      last_grant       <= PW'(NUM_PORTS - 1);
      beat_cnt         <= '0;
      disc_from_idle   <= 1'b0;
      frames_forwarded <= '0;
      frames_discarded <= '0;
      frames_truncated <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            grant      <= arb_grant;
            last_grant <= arb_grant;
            beat_cnt   <= '0;
            if (port_enable[arb_grant]) begin
              state <= FORWARD;
            end else begin
              state          <= DISCARD;
              disc_from_idle <= 1'b1;
            end
          end
        end
        FORWARD: begin
          if (fwd_hs) begin
            beat_cnt <= beat_cnt + BW'(1);
            if (at_limit) begin
              frames_truncated <= frames_truncated + 32'd1;
              if (sel_last) begin
                state <= IDLE;
              end else begin
                state          <= DISCARD;
                disc_from_idle <= 1'b0;
              end
            end else if (sel_last) begin
              frames_forwarded <= frames_forwarded + 32'd1;
              state            <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (disc_hs && sel_last) begin
            if (disc_from_idle) begin
              frames_discarded <= frames_discarded + 32'd1;
            end
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_fabric_arbiter.sv
// Randomized scoreboard bench for switch_fabric_arbiter. Per-port sources
// replay queued frames; a frame-level reference model predicts the egress
// beat sequence and event counters; a monitor pops and compares each beat.
module tb_switch_fabric_arbiter;

  localparam int NP        = 5;
  localparam int DW        = 16;
  localparam int MB        = 5;
  localparam int PW        = $clog2(NP);
  localparam int SRC_DEPTH = 64;

  logic              clk_fabric = 1'b0;
  logic              rst_n      = 1'b0;
  logic [NP-1:0]     in_tvalid;
  logic [NP-1:0]     in_tready;
  logic [NP*DW-1:0]  in_tdata;
  logic [NP-1:0]     in_tlast;
  logic [NP-1:0]     in_tuser;
  logic [NP-1:0]     port_enable;
  logic              out_tvalid;
  logic              out_tready;
  logic [DW-1:0]     out_tdata;
  logic              out_tlast;
  logic              out_tuser;
  logic [PW-1:0]     out_tdest;
  logic [31:0]       frames_forwarded;
  logic [31:0]       frames_discarded;
  logic [31:0]       frames_truncated;

  switch_fabric_arbiter #(
    .NUM_PORTS  (NP),
    .DATA_WIDTH (DW),
    .MAX_BEATS  (MB)
  ) dut (
    .clk_fabric       (clk_fabric),
    .rst_n            (rst_n),
    .in_tvalid        (in_tvalid),
    .in_tready        (in_tready),
    .in_tdata         (in_tdata),
    .in_tlast         (in_tlast),
    .in_tuser         (in_tuser),
    .port_enable      (port_enable),
    .out_tvalid       (out_tvalid),
    .out_tready       (out_tready),
    .out_tdata        (out_tdata),
    .out_tlast        (out_tlast),
    .out_tuser        (out_tuser),
    .out_tdest        (out_tdest),
    .frames_forwarded (frames_forwarded),
    .frames_discarded (frames_discarded),
    .frames_truncated (frames_truncated)
  );

  always #5 clk_fabric = ~clk_fabric;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
  } beat_t;

  typedef struct packed {
    logic [PW-1:0] dest;
    logic          user;
    logic          last;
    logic [DW-1:0] data;
  } exp_t;

  beat_t src_mem [NP][SRC_DEPTH];
  int    src_head [NP];
  int    src_tail [NP];
  bit    started  [NP];
  exp_t  exp_q [$];

  int total = 0;
  int bad   = 0;
  int m_fwd, m_disc, m_trunc, m_last_grant;
  bit gaps_on, rand_ready, hold_reset, prev_last_hs;
  int round_len [NP];
  bit round_en  [NP];

  // One counted comparison; a mismatch prints a single FAIL line.
  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Append a frame of len beats to port p's source; returns its first index.
  task automatic gen_frame(input int p, input int len, output int start);
    beat_t b;
    start = src_tail[p];
    for (int k = 0; k < len; k++) begin
      b.data = DW'($urandom);
      b.user = ($urandom_range(0, 7) == 0);
      b.last = (k == len - 1);
      src_mem[p][src_tail[p] % SRC_DEPTH] = b;
      src_tail[p]++;
    end
  endtask

  // Frame-level reference: what leaves the egress for this frame, and which
  // counter moves. Disabled -> nothing out; beat MB forces last/user and ends.
  task automatic model_frame(input int p, input int start, input int len, input bit en);
    beat_t b;
    exp_t  e;
    if (!en) begin
      m_disc++;
      return;
    end
    for (int k = 0; k < len; k++) begin
      b      = src_mem[p][(start + k) % SRC_DEPTH];
      e.dest = PW'(p);
      e.data = b.data;
      if (k == MB - 1) begin
        e.last = 1'b1;
        e.user = 1'b1;
        exp_q.push_back(e);
        m_trunc++;
        return;
      end
      e.last = b.last;
      e.user = b.user;
      exp_q.push_back(e);
    end
    m_fwd++;
  endtask

  // Drive every source on the falling edge, then record which heads were
  // accepted just before the next rising edge.
  task automatic apply_stimulus();
    beat_t b;
    @(negedge clk_fabric);
    rst_n = !hold_reset;
    for (int p = 0; p < NP; p++) begin
      if (src_head[p] != src_tail[p]) begin
        b = src_mem[p][src_head[p] % SRC_DEPTH];
        in_tvalid[p]          = !(gaps_on && started[p] && ($urandom_range(0, 3) == 0));
        in_tdata[p*DW +: DW]  = b.data;
        in_tlast[p]           = b.last;
        in_tuser[p]           = b.user;
      end else begin
        in_tvalid[p]          = 1'b0;
        in_tdata[p*DW +: DW]  = '0;
        in_tlast[p]           = 1'b0;
        in_tuser[p]           = 1'b0;
      end
    end
    out_tready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    #4;
    for (int p = 0; p < NP; p++) begin
      if (in_tvalid[p] && in_tready[p]) begin
        b = src_mem[p][src_head[p] % SRC_DEPTH];
        src_head[p]++;
        started[p] = !b.last;
      end
    end
  endtask

  // Run until every source is empty (bounded), then confirm the scoreboard drained.
  task automatic drain(input string name);
    int n;
    bit busy;
    n    = 0;
    busy = 1'b1;
    while (busy && n < 600) begin
      apply_stimulus();
      n++;
      busy = 1'b0;
      for (int p = 0; p < NP; p++) if (src_head[p] != src_tail[p]) busy = 1'b1;
    end
    check_eq({name, "_timeout"}, 64'(busy), 64'd0);
    if (busy) begin
      for (int p = 0; p < NP; p++) begin
        src_head[p] = src_tail[p];
        started[p]  = 1'b0;
      end
    end
    repeat (2) apply_stimulus();
    check_eq({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // Present one frame on each masked port at once; the model serves them in
  // rotation starting just after the previously served port.
  task automatic run_round(input logic [NP-1:0] mask, input string name);
    int lg, p, s;
    lg = m_last_grant;
    for (int k = 1; k <= NP; k++) begin
      p = (m_last_grant + k) % NP;
      if (mask[p]) begin
        port_enable[p] = round_en[p];
        gen_frame(p, round_len[p], s);
        model_frame(p, s, round_len[p], round_en[p]);
        lg = p;
      end
    end
    m_last_grant = lg;
    drain(name);
  endtask

  task automatic check_counters(input string name);
    check_eq({name, "_fwd"},   64'(frames_forwarded), 64'(m_fwd));
    check_eq({name, "_disc"},  64'(frames_discarded), 64'(m_disc));
    check_eq({name, "_trunc"}, 64'(frames_truncated), 64'(m_trunc));
  endtask

  task automatic check_reset_outputs(input string name);
    check_eq({name, "_in_tready"},  64'(in_tready),  64'd0);
    check_eq({name, "_out_tvalid"}, 64'(out_tvalid), 64'd0);
    check_eq({name, "_out_tlast"},  64'(out_tlast),  64'd0);
    check_eq({name, "_out_tuser"},  64'(out_tuser),  64'd0);
    check_eq({name, "_out_tdest"},  64'(out_tdest),  64'd0);
    check_eq({name, "_out_tdata"},  64'(out_tdata),  64'd0);
  endtask

  // Per-cycle protocol checks plus scoreboard pop on every egress handshake.
  task automatic check_output();
    exp_t e;
    if (!rst_n) begin
      prev_last_hs = 1'b0;
      return;
    end
    check_eq("ready_onehot", 64'($countones(in_tready) <= 1), 64'd1);
    if (out_tvalid) check_eq("ready_mirror", 64'(in_tready[out_tdest]), 64'(out_tready));
    if (prev_last_hs) check_eq("idle_bubble", 64'(out_tvalid), 64'd0);
    if (out_tvalid && out_tready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_beat: got dest=%0d data=0x%0h expected no beat at %0t",
                 out_tdest, out_tdata, $time);
      end else begin
        e = exp_q.pop_front();
        check_eq("beat", 64'({out_tdest, out_tuser, out_tlast, out_tdata}), 64'(e));
      end
    end
    prev_last_hs = out_tvalid && out_tready && out_tlast;
  endtask

  // Monitor runs independently of the stimulus, just before each rising edge.
  always @(negedge clk_fabric) begin
    #4;
    check_output();
  end

  // Hard stop in case something wedges outside the bounded drains.
  initial begin
    #900000;
    bad++;
    $display("[TB] FAIL watchdog: got no finish expected finish before %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Directed scenarios first, then randomized rounds, then reset mid-frame.
  initial begin
    int s, s3, n;
    logic [NP-1:0] mask;

    hold_reset  = 1'b1;
    gaps_on     = 1'b0;
    rand_ready  = 1'b0;
    in_tvalid   = '1;
    in_tdata    = '1;
    in_tlast    = '0;
    in_tuser    = '1;
    port_enable = '1;
    out_tready  = 1'b1;
    m_fwd = 0; m_disc = 0; m_trunc = 0;
    m_last_grant = NP - 1;

    repeat (2) @(negedge clk_fabric);
    #4;
    check_reset_outputs("reset");
    check_counters("reset");
    hold_reset = 1'b0;

    for (int p = 0; p < NP; p++) begin
      round_len[p] = 4;
      round_en[p]  = 1'b1;
    end
    run_round(5'b00111, "three_ports");
    check_counters("three_ports");

    round_len[3] = 5;
    round_en[3]  = 1'b0;
    run_round(5'b01000, "disabled_port");
    check_counters("disabled_port");

    round_len[4] = 7;
    round_en[4]  = 1'b1;
    run_round(5'b10000, "truncate");
    check_counters("truncate");

    round_len[2] = MB;
    round_en[2]  = 1'b1;
    run_round(5'b00100, "exact_max");
    check_counters("exact_max");

    port_enable = '1;
    gen_frame(1, 4, s);
    model_frame(1, s, 4, 1'b1);
    m_last_grant = 1;
    n = 0;
    while ((src_head[1] - s) < 2 && n < 50) begin
      apply_stimulus();
      n++;
    end
    port_enable[1] = 1'b0;
    drain("enable_drop");
    gen_frame(1, 3, s);
    model_frame(1, s, 3, 1'b0);
    drain("enable_next");
    check_counters("enable_change");

    gaps_on    = 1'b1;
    rand_ready = 1'b1;
    for (int p = 0; p < NP; p++) begin
      round_len[p] = 2;
      round_en[p]  = 1'b1;
    end
    run_round('1, "all_ports");
    for (int r = 0; r < 40; r++) begin
      mask = NP'($urandom_range(1, (1 << NP) - 1));
      for (int p = 0; p < NP; p++) begin
        round_len[p] = $urandom_range(1, 8);
        round_en[p]  = ($urandom_range(0, 3) != 0);
      end
      run_round(mask, "random");
    end
    check_counters("random");

    gaps_on     = 1'b0;
    rand_ready  = 1'b0;
    port_enable = '1;
    gen_frame(0, 6, s);
    model_frame(0, s, 6, 1'b1);
    n = 0;
    while ((src_head[0] - s) < 3 && n < 50) begin
      apply_stimulus();
      n++;
    end
    check_eq("mid_reset_reached", 64'(src_head[0] - s), 64'd3);
    hold_reset = 1'b1;
    apply_stimulus();
    check_reset_outputs("mid_reset");
    hold_reset = 1'b0;
    exp_q.delete();
    m_fwd = 0; m_disc = 0; m_trunc = 0;
    gen_frame(3, 3, s3);
    model_frame(0, s + 3, 3, 1'b1);
    model_frame(3, s3, 3, 1'b1);
    m_last_grant = 3;
    drain("post_reset");
    check_counters("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
